// File: rtl/fix_sched_pkg.sv
// fix_sched_pkg: shared widths, message codes, state and order types for the scheduler.
package fix_sched_pkg;
  localparam int HOST_ADDR_WIDTH = 8;
  localparam int VALUE_DATA_WIDTH = 32;
  localparam int VALUE_SIZE = 3;
  localparam int STARVE_W = 8;
  localparam int WD_W = 16;
  localparam logic [3:0] MSG_LOGON = 4'h1;
  localparam logic [3:0] MSG_LOGOUT = 4'h2;
  localparam logic [3:0] MSG_HEARTBEAT = 4'h3;
  localparam logic [3:0] MSG_RESEND_REQ = 4'h4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  typedef struct packed {
    logic [3:0] msg_type;
    logic [HOST_ADDR_WIDTH-1:0] host;
    logic [VALUE_DATA_WIDTH-1:0] tcid;
    logic [VALUE_SIZE-1:0] tcid_size;
  } order_t;
endpackage

// File: rtl/adm_req_fifo.sv
// adm_req_fifo: synchronous order FIFO; a push into a full FIFO succeeds only alongside a pop.
module adm_req_fifo
  import fix_sched_pkg::*;
#(
  parameter type T = order_t,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic wr_en, rd_en;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata = mem[rd_q[AW-1:0]];
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fix_msg_scheduler.sv
// fix_msg_scheduler: queues admin orders, arbitrates them against app orders with a starvation
// limit, and issues one order at a time to create-message, guarded by a completion watchdog.
module fix_msg_scheduler
  import fix_sched_pkg::*;
#(
  parameter int HOST_W = HOST_ADDR_WIDTH,
  parameter int VALUE_W = VALUE_DATA_WIDTH,
  parameter int SIZE_W = VALUE_SIZE,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adm_valid_i,
  input  logic [3:0]         adm_type_i,
  input  logic [HOST_W-1:0]  adm_host_i,
  input  logic [VALUE_W-1:0] adm_tcid_i,
  input  logic [SIZE_W-1:0]  adm_tcid_size_i,
  output logic               adm_overflow_o,
  input  logic               app_valid_i,
  output logic               app_ready_o,
  input  logic [3:0]         app_type_i,
  input  logic [HOST_W-1:0]  app_host_i,
  input  logic [VALUE_W-1:0] app_tcid_i,
  input  logic [SIZE_W-1:0]  app_tcid_size_i,
  output logic [3:0]         create_message_o,
  output logic [HOST_W-1:0]  msg_host_o,
  output logic [VALUE_W-1:0] targetCompId_o,
  output logic [SIZE_W-1:0]  s_v_targetCompId_o,
  output logic               initiate_msg_o,
  input  logic               create_done_i,
  output logic               busy_o,
  output logic               timeout_err_o
);
  typedef struct packed {
    logic [3:0] msg_type;
    logic [HOST_W-1:0] host;
    logic [VALUE_W-1:0] tcid;
    logic [SIZE_W-1:0] tcid_size;
  } ord_t;
  state_t state_q, state_d;
  ord_t adm_ord, adm_head, app_ord, out_q;
  logic full, empty, adm_sel, app_sel, expire, starved;
  logic initiate_q, timeout_q, ovf_q;
  logic [STARVE_W-1:0] starve_q;
  logic [WD_W-1:0] wd_q;
  assign adm_ord = {adm_type_i, adm_host_i, adm_tcid_i, adm_tcid_size_i};
  assign app_ord = {app_type_i, app_host_i, app_tcid_i, app_tcid_size_i};
  adm_req_fifo #(.T(ord_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(adm_valid_i), .pop(adm_sel), .wdata(adm_ord),
    .rdata(adm_head), .full(full), .empty(empty)
  );
  assign starved = starve_q == STARVE_W'(STARVE_LIMIT);
  assign adm_sel = (state_q == IDLE) && !empty && (!app_valid_i || starve_q < STARVE_W'(STARVE_LIMIT));
  assign app_ready_o = (state_q == IDLE) && !rst && (empty || starved);
  assign app_sel = app_valid_i && app_ready_o;
  assign expire = (state_q == WAIT_DONE) && (wd_q == WD_W'(DONE_TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = (adm_sel || app_sel) ? ISSUE : IDLE;
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: state_d = (create_done_i || expire) ? IDLE : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
  end
  // Admin grants only advance the starve count while an app order is actually waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      starve_q <= '0;
      wd_q <= '0;
      out_q <= '0;
      initiate_q <= 1'b0;
      timeout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (adm_sel) starve_q <= app_valid_i ? starve_q + 1'b1 : '0;
      else if (app_sel) starve_q <= '0;
      if (adm_sel || app_sel) out_q <= adm_sel ? adm_head : app_ord;
      wd_q <= (state_q == ISSUE) ? '0 : (state_q == WAIT_DONE) ? wd_q + 1'b1 : wd_q;
      initiate_q <= state_q == ISSUE;
      timeout_q <= expire && !create_done_i;
      ovf_q <= ovf_q || (adm_valid_i && full && !adm_sel);
    end
  end
  assign create_message_o = out_q.msg_type;
  assign msg_host_o = out_q.host;
  assign targetCompId_o = out_q.tcid;
  assign s_v_targetCompId_o = out_q.tcid_size;
  assign initiate_msg_o = initiate_q;
  assign busy_o = state_q != IDLE;
  assign timeout_err_o = timeout_q;
  assign adm_overflow_o = ovf_q;
endmodule

// File: tb/tb_fix_msg_scheduler.sv
// tb_fix_msg_scheduler: directed vectors with hand-computed expectations for fix_msg_scheduler.
module tb_fix_msg_scheduler;
  import fix_sched_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic adm_valid = 1'b0, app_valid = 1'b0, create_done = 1'b0;
  logic [3:0] adm_type = '0, app_type = '0, create_message;
  logic [7:0] adm_host = '0, app_host = '0, msg_host;
  logic [31:0] adm_tcid = 32'h4142_4300, app_tcid = 32'h5859_5a00, tcid;
  logic [2:0] adm_size = 3'd3, app_size = 3'd4, tcid_size;
  logic adm_overflow, app_ready, initiate, busy, timeout_err;
  int n_vec = 0, n_bad = 0;
  logic flag;
  logic [3:0] ty [4] = '{MSG_LOGON, MSG_LOGOUT, MSG_HEARTBEAT, MSG_RESEND_REQ};
  logic [7:0] ho [4] = '{8'd1, 8'd2, 8'd4, 8'd5};

  fix_msg_scheduler dut (
    .clk(clk), .rst(rst),
    .adm_valid_i(adm_valid), .adm_type_i(adm_type), .adm_host_i(adm_host),
    .adm_tcid_i(adm_tcid), .adm_tcid_size_i(adm_size), .adm_overflow_o(adm_overflow),
    .app_valid_i(app_valid), .app_ready_o(app_ready), .app_type_i(app_type),
    .app_host_i(app_host), .app_tcid_i(app_tcid), .app_tcid_size_i(app_size),
    .create_message_o(create_message), .msg_host_o(msg_host), .targetCompId_o(tcid),
    .s_v_targetCompId_o(tcid_size), .initiate_msg_o(initiate), .create_done_i(create_done),
    .busy_o(busy), .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic adm(input logic [3:0] t, input logic [7:0] h);
    adm_valid = 1'b1;
    adm_type = t;
    adm_host = h;
    tick();
    adm_valid = 1'b0;
  endtask

  task automatic done_pulse;
    create_done = 1'b1;
    tick();
    create_done = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("reset_outs", {create_message, msg_host, tcid, tcid_size, initiate, busy, adm_overflow,
        timeout_err, app_ready}, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", app_ready, 1);
    chk("idle_busy", busy, 0);
    // single heartbeat, host 3
    adm(MSG_HEARTBEAT, 8'd3);
    chk("hb_k_busy", busy, 0);
    tick();
    chk("hb_sel_busy", busy, 1);
    chk("hb_sel_init", initiate, 0);
    tick();
    chk("hb_init", initiate, 1);
    chk("hb_type", create_message, MSG_HEARTBEAT);
    chk("hb_host", msg_host, 3);
    chk("hb_tcid", {tcid, tcid_size}, {32'h4142_4300, 3'd3});
    tick();
    chk("hb_pulse_len", initiate, 0);
    chk("hb_wait_busy", busy, 1);
    done_pulse();
    chk("hb_done_busy", busy, 0);
    // app order, then five admin pulses while it waits
    app_valid = 1'b1;
    app_type = MSG_LOGOUT;
    app_host = 8'd9;
    #1;
    chk("app_ready", app_ready, 1);
    tick();
    app_valid = 1'b0;
    chk("app_k_init", initiate, 0);
    tick();
    chk("app_init", initiate, 1);
    chk("app_type", create_message, MSG_LOGOUT);
    chk("app_host", {msg_host, tcid, tcid_size}, {8'd9, 32'h5859_5a00, 3'd4});
    adm(MSG_LOGON, 8'd1);
    adm(MSG_LOGOUT, 8'd2);
    adm(MSG_HEARTBEAT, 8'd4);
    adm(MSG_RESEND_REQ, 8'd5);
    chk("ovf_not_yet", adm_overflow, 0);
    adm(MSG_LOGON, 8'd6);
    chk("ovf_set", adm_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      done_pulse();
      chk("q_idle", busy, 0);
      tick();
      chk("q_sel_init", initiate, 0);
      tick();
      chk("q_init", initiate, 1);
      chk("q_type", create_message, ty[i]);
      chk("q_host", msg_host, ho[i]);
    end
    done_pulse();
    repeat (5) tick();
    chk("fifth_dropped", busy, 0);
    chk("ovf_sticky", adm_overflow, 1);
    // starvation: continuous admin backlog with an app order waiting
    adm(MSG_LOGON, 8'd10);
    tick();
    tick();
    chk("st_a0_init", initiate, 1);
    for (int h = 11; h < 15; h++) adm(MSG_HEARTBEAT, 8'(h));
    app_valid = 1'b1;
    app_type = MSG_RESEND_REQ;
    app_host = 8'd7;
    for (int i = 0; i < 5; i++) begin
      done_pulse();
      chk("st_ready", app_ready, (i == 4) ? 1 : 0);
      chk("st_cnt", dut.starve_q, i);
      tick();
      if (i == 4) app_valid = 1'b0;
      tick();
      chk("st_host", msg_host, (i < 4) ? 11 + i : 7);
      if (i < 4) adm(MSG_HEARTBEAT, 8'(15 + i));
    end
    chk("st_cleared", dut.starve_q, 0);
    // watchdog: no done after the app order's initiate
    flag = 1'b0;
    repeat (1022) begin
      tick();
      if (timeout_err || !busy) flag = 1'b1;
    end
    chk("wd_early", flag, 0);
    tick();
    chk("wd_pulse", timeout_err, 1);
    chk("wd_idle", busy, 0);
    tick();
    chk("wd_pulse_len", timeout_err, 0);
    chk("wd_next_sel", busy, 1);
    tick();
    chk("wd_next_init", initiate, 1);
    chk("wd_next_host", msg_host, 15);
    // reset while waiting with three orders queued
    tick();
    rst = 1'b1;
    tick();
    chk("rst_outs", {create_message, msg_host, tcid, tcid_size, initiate, busy, adm_overflow,
        timeout_err, app_ready}, 64'd0);
    chk("rst_state", dut.state_q, IDLE);
    rst = 1'b0;
    flag = 1'b0;
    repeat (10) begin
      tick();
      if (initiate || busy) flag = 1'b1;
    end
    chk("rst_flushed", flag, 0);
    chk("rst_ovf", adm_overflow, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
